// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state enum and constants for the PC sequencer
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_WAIT,
    S_HALT
  } pc_state_e;

  localparam logic [31:0] PC_INCR             = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/pc_target_select.sv
// rtl/pc_target_select.sv - redirect priority, target pick and alignment handling (PC_SEQ_TRAP_EN)
module pc_target_select
  import pc_sequencer_pkg::*;
`ifdef PC_SEQ_TRAP_EN
#(
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
)
`endif
(
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        redirect,
`ifdef PC_SEQ_TRAP_EN
  output logic        misaligned,
`endif
  output logic [31:0] target
);

  logic [31:0] raw_target;

  // Jump outranks a taken branch; misaligned targets either trap or get their low bits cleared
  always_comb begin
    redirect   = Jump | BranchTaken;
    raw_target = Jump ? JumpTarget : BranchTarget;
`ifdef PC_SEQ_TRAP_EN
    misaligned = redirect && (raw_target[1:0] != 2'b00);
    target     = misaligned ? TRAP_VECTOR : raw_target;
`else
    target     = {raw_target[31:2], 2'b00};
`endif
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC write-enable/next-value FSM with stalled-redirect buffer (PC_SEQ_TRAP_EN)
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
`ifdef PC_SEQ_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
`endif
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        IMemReady,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Halt,
  input  logic        Resume,
  output logic        PCWrite,
  output logic [31:0] PCNext,
  output logic        Flush,
`ifdef PC_SEQ_TRAP_EN
  output logic        Trap,
`endif
  output logic        Halted
);

  pc_state_e   state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic        redirect;
  logic [31:0] target;
`ifdef PC_SEQ_TRAP_EN
  logic        misaligned;
`endif

  pc_target_select
`ifdef PC_SEQ_TRAP_EN
  #(
    .TRAP_VECTOR (TRAP_VECTOR)
  )
`endif
  u_target_select (
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .redirect     (redirect),
`ifdef PC_SEQ_TRAP_EN
    .misaligned   (misaligned),
`endif
    .target       (target)
  );

  // State and buffered redirect target
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_BOOT;
      pending_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Next-state and PC control; reset forces the outputs quiet regardless of state
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    PCWrite   = 1'b0;
    PCNext    = PC + PC_INCR;
    Flush     = 1'b0;
`ifdef PC_SEQ_TRAP_EN
    Trap      = 1'b0;
`endif
    case (state_q)
      S_BOOT: begin
        PCWrite = 1'b1;
        PCNext  = RESET_PC;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (Halt) begin
          // Halt beats any concurrent redirect, which is dropped
          Flush   = 1'b1;
          state_d = S_HALT;
        end else if (redirect) begin
          Flush = 1'b1;
`ifdef PC_SEQ_TRAP_EN
          Trap  = misaligned;
`endif
          if (Stall) begin
            pending_d = target;
            state_d   = S_WAIT;
          end else begin
            PCWrite = 1'b1;
            PCNext  = target;
          end
        end else begin
          PCWrite = IMemReady & ~Stall;
        end
      end
      S_WAIT: begin
        // Producing stage is already flushed, so new redirects/halts are ignored here
        PCNext = pending_q;
        if (!Stall) begin
          PCWrite = 1'b1;
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        if (Resume) begin
          PCWrite = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
    if (Reset) begin
      PCWrite = 1'b0;
      PCNext  = RESET_PC;
      Flush   = 1'b0;
`ifdef PC_SEQ_TRAP_EN
      Trap    = 1'b0;
`endif
    end
  end

  assign Halted = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed plus randomized check of pc_sequencer against a behavioural model (PC_SEQ_TRAP_EN)
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef PC_SEQ_TRAP_EN
  localparam logic [31:0] TVEC   = 32'h0000_0080;
`endif

  logic        Clk = 1'b0;
  logic        Reset, IMemReady, Stall, BranchTaken, Jump, Halt, Resume;
  logic [31:0] PC, BranchTarget, JumpTarget;
  logic        PCWrite, Flush, Halted;
  logic [31:0] PCNext;
`ifdef PC_SEQ_TRAP_EN
  logic        Trap;
  logic        e_t;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: boot pending, halted, buffered redirect
  bit          m_known = 0;
  bit          m_boot, m_halted, m_pend_v;
  logic [31:0] m_pend;
  logic        e_w, e_f;
  logic [31:0] e_n;

  pc_sequencer #(
    .RESET_PC (RST_PC)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PC           (PC),
    .IMemReady    (IMemReady),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Halt         (Halt),
    .Resume       (Resume),
    .PCWrite      (PCWrite),
    .PCNext       (PCNext),
    .Flush        (Flush),
`ifdef PC_SEQ_TRAP_EN
    .Trap         (Trap),
`endif
    .Halted       (Halted)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fix_target(input logic [31:0] t);
`ifdef PC_SEQ_TRAP_EN
    return (t % 4 != 0) ? TVEC : t;
`else
    return t - (t % 4);
`endif
  endfunction

  function automatic logic [31:0] chosen_target();
    return Jump ? JumpTarget : BranchTarget;
  endfunction

  // Expected outputs for the current inputs, then compare
  task automatic settle();
    #1;
    e_w = 0; e_f = 0; e_n = PC + 4;
`ifdef PC_SEQ_TRAP_EN
    e_t = 0;
`endif
    if (Reset) begin
      e_n = RST_PC;
    end else if (m_boot) begin
      e_w = 1; e_n = RST_PC;
    end else if (m_halted) begin
      e_w = Resume;
    end else if (m_pend_v) begin
      e_w = !Stall; e_n = m_pend;
    end else if (Halt) begin
      e_f = 1;
    end else if (Jump || BranchTaken) begin
      e_f = 1;
      e_w = !Stall;
      e_n = fix_target(chosen_target());
`ifdef PC_SEQ_TRAP_EN
      e_t = (chosen_target() % 4 != 0);
`endif
    end else begin
      e_w = IMemReady && !Stall;
    end
    chk("PCWrite", {31'b0, PCWrite}, {31'b0, e_w});
    chk("Flush", {31'b0, Flush}, {31'b0, e_f});
    if (Reset || e_w) chk("PCNext", PCNext, e_n);
    if (m_known) chk("Halted", {31'b0, Halted}, {31'b0, m_halted});
`ifdef PC_SEQ_TRAP_EN
    chk("Trap", {31'b0, Trap}, {31'b0, e_t});
`endif
  endtask

  // Advance model across the clock edge, then move to the drive point
  task automatic tick();
    @(posedge Clk);
    if (Reset) begin
      m_known = 1; m_boot = 1; m_halted = 0; m_pend_v = 0; m_pend = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halted) begin
      if (Resume) m_halted = 0;
    end else if (m_pend_v) begin
      if (!Stall) m_pend_v = 0;
    end else if (Halt) begin
      m_halted = 1;
    end else if ((Jump || BranchTaken) && Stall) begin
      m_pend_v = 1;
      m_pend   = fix_target(chosen_target());
    end
    if (e_w) PC = e_n;
    @(negedge Clk);
  endtask

  task automatic clear_inputs();
    IMemReady = 0; Stall = 0; BranchTaken = 0; Jump = 0; Halt = 0; Resume = 0;
    BranchTarget = 0; JumpTarget = 0;
  endtask

  initial begin
    clear_inputs();
    Reset = 1; PC = 0;
    settle();
    chk("rst_pcwrite", {31'b0, PCWrite}, 32'h0);
    chk("rst_pcnext", PCNext, 32'h100);
    chk("rst_flush", {31'b0, Flush}, 32'h0);
    tick();
    settle(); tick();
    Reset = 0;
    settle();
    chk("boot_pcwrite", {31'b0, PCWrite}, 32'h1);
    chk("boot_pcnext", PCNext, 32'h100);
    tick();
    IMemReady = 1;
    settle();
    chk("seq_pcnext", PCNext, 32'h104);
    tick();
    PC = 32'h200; BranchTaken = 1; BranchTarget = 32'h40;
    settle();
    chk("br_pcwrite", {31'b0, PCWrite}, 32'h1);
    chk("br_pcnext", PCNext, 32'h40);
    chk("br_flush", {31'b0, Flush}, 32'h1);
    tick();
    Jump = 1; JumpTarget = 32'h80;
    settle();
    chk("jmp_prio", PCNext, 32'h80);
    tick();
    BranchTaken = 0; JumpTarget = 32'h300; Stall = 1;
    settle();
    chk("stall_redir_w", {31'b0, PCWrite}, 32'h0);
    chk("stall_redir_f", {31'b0, Flush}, 32'h1);
    tick();
    Jump = 0; BranchTaken = 1; BranchTarget = 32'h44; Halt = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("wait_w", {31'b0, PCWrite}, 32'h0);
      chk("wait_f", {31'b0, Flush}, 32'h0);
      tick();
    end
    BranchTaken = 0; Halt = 0; Stall = 0;
    settle();
    chk("wait_rel_w", {31'b0, PCWrite}, 32'h1);
    chk("wait_rel_n", PCNext, 32'h300);
    tick();
    PC = 32'h50; Halt = 1;
    settle();
    chk("halt_f", {31'b0, Flush}, 32'h1);
    tick();
    Halt = 0;
    for (int i = 0; i < 3; i++) begin
      BranchTaken = (i % 2 == 0); BranchTarget = 32'h60;
      settle();
      chk("halted_hi", {31'b0, Halted}, 32'h1);
      chk("halted_w", {31'b0, PCWrite}, 32'h0);
      tick();
    end
    BranchTaken = 0; Resume = 1;
    settle();
    chk("resume_w", {31'b0, PCWrite}, 32'h1);
    chk("resume_n", PCNext, 32'h54);
    tick();
    Resume = 0;
    settle();
    chk("halted_lo", {31'b0, Halted}, 32'h0);
    tick();
    PC = 32'h110; BranchTaken = 1; BranchTarget = 32'h102;
    settle();
`ifdef PC_SEQ_TRAP_EN
    chk("mis_n", PCNext, 32'h80);
    chk("mis_trap", {31'b0, Trap}, 32'h1);
`else
    chk("mis_n", PCNext, 32'h100);
`endif
    tick();
    BranchTaken = 0;
    settle();
`ifdef PC_SEQ_TRAP_EN
    chk("trap_pulse_end", {31'b0, Trap}, 32'h0);
`endif
    tick();
    PC = 32'hFFFF_FFFC;
    settle();
    chk("wrap_n", PCNext, 32'h0);
    tick();
    Jump = 1; JumpTarget = 32'h500; Stall = 1;
    settle(); tick();
    Jump = 0; Reset = 1;
    settle(); tick();
    Reset = 0; Stall = 0;
    settle(); tick();
    settle();
    chk("rst_drop_pend", PCNext, 32'h104);
    tick();
    Halt = 1;
    settle(); tick();
    Halt = 0; Reset = 1;
    settle();
    chk("halt_rst_still", {31'b0, Halted}, 32'h1);
    tick();
    Reset = 0;
    settle();
    chk("halt_rst_clr", {31'b0, Halted}, 32'h0);
    tick();

    for (int i = 0; i < 3000; i++) begin
      Reset        = ($urandom_range(0, 99) < 2);
      Stall        = ($urandom_range(0, 99) < 35);
      IMemReady    = ($urandom_range(0, 99) < 75);
      Jump         = ($urandom_range(0, 99) < 15);
      BranchTaken  = ($urandom_range(0, 99) < 20);
      Halt         = ($urandom_range(0, 99) < 6);
      Resume       = ($urandom_range(0, 99) < 25);
      JumpTarget   = $urandom;
      BranchTarget = $urandom;
      if ($urandom_range(0, 99) < 3) PC = 32'hFFFF_FFFC;
      else if ($urandom_range(0, 99) < 5) PC = $urandom;
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
